// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding a console TX FIFO,
// a 64-bit free-running cycle timer with a high-word shadow, and a sticky tohost halt register.
module dmem_responder #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     RAM_WORDS  = 1024,
  parameter logic [XLEN-1:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [XLEN-1:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned     FIFO_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            halt,
  output logic [XLEN-1:0] halt_code
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // MMIO register word offsets (address[7:2])
  localparam logic [5:0] OffTxData = 6'h00;
  localparam logic [5:0] OffTxStat = 6'h01;
  localparam logic [5:0] OffTimeLo = 6'h02;
  localparam logic [5:0] OffTimeHi = 6'h03;
  localparam logic [5:0] OffToHost = 6'h04;

  logic            ram_hit, mmio_hit;
  logic [5:0]      mmio_off;
  logic [AW-1:0]   ram_idx;
  logic            unused_addr_lsb;

  assign ram_hit         = (address[XLEN-1:AW+2] == RAM_BASE[XLEN-1:AW+2]);
  assign mmio_hit        = (address[XLEN-1:8] == MMIO_BASE[XLEN-1:8]);
  assign mmio_off        = address[7:2];
  assign ram_idx         = address[AW+1:2];
  assign unused_addr_lsb = ^address[1:0];

  logic [XLEN-1:0] mem [RAM_WORDS];
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic [63:0]     timer_q, timer_d;
  logic [31:0]     shadow_q, shadow_d;
  logic            ovf_q, ovf_d;
  logic            halt_q, halt_d;
  logic [XLEN-1:0] halt_code_q, halt_code_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            wr_en, ram_we, push_req, push, pop, full;
  logic [XLEN-1:0] txstat;

  // Every store is suppressed once halted; loads and the FIFO drain still proceed.
  assign wr_en    = mem_store & ~halt_q;
  assign ram_we   = wr_en & ram_hit & ~mmio_hit;
  assign push_req = wr_en & mmio_hit & (mmio_off == OffTxData);
  assign tx_valid = (count_q != '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = tx_valid & tx_ready;
  assign push     = push_req & (~full | pop);

  always_comb begin
    timer_d     = timer_q + 64'd1;
    shadow_d    = shadow_q;
    ovf_d       = ovf_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);

    if (mem_load && mmio_hit && (mmio_off == OffTimeLo)) shadow_d = timer_q[63:32];
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_en && mmio_hit && (mmio_off == OffTxStat)) begin
      ovf_d = 1'b0;
    end
    if (wr_en && mmio_hit && (mmio_off == OffToHost) && (store_data != '0)) begin
      halt_d      = 1'b1;
      halt_code_d = store_data;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q     <= '0;
      shadow_q    <= '0;
      ovf_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      timer_q     <= timer_d;
      shadow_q    <= shadow_d;
      ovf_q       <= ovf_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage arrays are not reset: RAM survives reset, FIFO is flushed via its pointers.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_idx] <= store_data;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= store_data[7:0];
  end

  assign tx_data   = fifo_mem[rd_ptr_q];
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

  always_comb begin
    txstat       = '0;
    txstat[15:8] = 8'(count_q);
    txstat[2]    = ovf_q;
    txstat[1]    = ~tx_valid;
    txstat[0]    = full;

    load_data = '0;
    if (mmio_hit) begin
      case (mmio_off)
        OffTxStat: load_data = txstat;
        OffTimeLo: load_data = XLEN'(timer_q[31:0]);
        OffTimeHi: load_data = XLEN'(shadow_q);
        OffToHost: load_data = halt_code_q;
        default:   load_data = '0;
      endcase
    end else if (ram_hit) begin
      load_data = mem[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus a randomized phase, all checked against
// a transaction-level model (associative RAM, byte queue, cycle counter).
module tb_dmem_responder;

  localparam int unsigned     RAM_WORDS = 1024;
  localparam int unsigned     DEPTH     = 8;
  localparam logic [31:0]     RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0]     MMIO      = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_load = 1'b0, mem_store = 1'b0, tx_ready = 1'b0;
  logic [31:0] address = '0, store_data = '0;
  logic [31:0] load_data, halt_code;
  logic [7:0]  tx_data;
  logic        tx_valid, halt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] mem_m [int];
  logic [7:0]  q [$];
  bit          ovf_m, halt_m;
  bit          timer_ok = 1'b1;
  logic [31:0] code_m, shadow_m;
  logic [63:0] timer_m;

  dmem_responder #(
    .XLEN      (32),
    .RAM_WORDS (RAM_WORDS),
    .RAM_BASE  (RAM_BASE),
    .MMIO_BASE (MMIO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_load  (mem_load),
    .mem_store (mem_store),
    .address   (address),
    .store_data(store_data),
    .load_data (load_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .halt      (halt),
    .halt_code (halt_code)
  );

  always #5 clock = ~clock;

  function automatic bit is_ram(logic [31:0] a);
    return (a >= RAM_BASE) && ((a - RAM_BASE) < 32'(RAM_WORDS * 4));
  endfunction

  function automatic bit is_mmio(logic [31:0] a);
    return (a & 32'hFFFF_FF00) == MMIO;
  endfunction

  function automatic int mmio_off(logic [31:0] a);
    return int'(a[7:0] & 8'hFC);
  endfunction

  function automatic int ram_key(logic [31:0] a);
    return int'((a - RAM_BASE) >> 2);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_load(string tag);
    logic [31:0] e;
    bit ok;
    ok = 1'b1;
    e  = '0;
    if (is_ram(address)) begin
      if (mem_m.exists(ram_key(address))) e = mem_m[ram_key(address)];
      else ok = 1'b0;
    end else if (is_mmio(address)) begin
      case (mmio_off(address))
        4:  e = (32'(q.size()) << 8) | (32'(ovf_m) << 2) | (32'(q.size() == 0) << 1)
                | 32'(q.size() == DEPTH);
        8:  if (timer_ok) e = timer_m[31:0]; else ok = 1'b0;
        12: e = shadow_m;
        16: e = code_m;
        default: e = '0;
      endcase
    end
    if (ok) chk(tag, load_data, e);
  endtask

  task automatic check_state(string tag);
    chk({tag, ".tx_valid"}, tx_valid, q.size() != 0);
    if (q.size() != 0) chk({tag, ".tx_data"}, tx_data, q[0]);
    chk({tag, ".halt"}, halt, halt_m);
    chk({tag, ".halt_code"}, halt_code, code_m);
  endtask

  // Advance the model by one clock using the currently driven inputs, then cross the edge.
  task automatic tick();
    bit pop, push;
    pop  = 1'b0;
    push = 1'b0;
    if (reset) begin
      q.delete();
      ovf_m    = 1'b0;
      halt_m   = 1'b0;
      code_m   = '0;
      shadow_m = '0;
      timer_m  = '0;
      timer_ok = 1'b1;
    end else begin
      pop = (q.size() != 0) && tx_ready;
      if (mem_load && is_mmio(address) && mmio_off(address) == 8) shadow_m = timer_m[63:32];
      if (mem_store && !halt_m) begin
        if (is_ram(address)) mem_m[ram_key(address)] = store_data;
        else if (is_mmio(address)) begin
          case (mmio_off(address))
            0:  push = 1'b1;
            4:  ovf_m = 1'b0;
            16: if (store_data != 0) begin halt_m = 1'b1; code_m = store_data; end
            default: ;
          endcase
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(store_data[7:0]);
        else ovf_m = 1'b1;
      end
      timer_m = timer_m + 64'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit ld, bit st, logic [31:0] a, logic [31:0] d);
    mem_load   = ld;
    mem_store  = st;
    address    = a;
    store_data = d;
    #1;
  endtask

  task automatic cyc(string tag, bit ld, bit st, logic [31:0] a, logic [31:0] d);
    drive(ld, st, a, d);
    chk_load({tag, ".load"});
    tick();
    check_state(tag);
  endtask

  initial begin
    logic [31:0] a;
    // Reset
    drive(0, 0, MMIO + 32'h20, 0);
    tick();
    tick();
    reset = 1'b0;
    check_state("reset");
    drive(0, 0, MMIO + 32'h04, 0);
    chk("reset.txstat", load_data, 32'h0000_0002);

    // 1: RAM store/load, unmapped
    cyc("ram_wr", 0, 1, 32'h40, 32'hDEAD_BEEF);
    drive(1, 0, 32'h40, 0);
    chk("ram_rd_40", load_data, 32'hDEAD_BEEF);
    drive(1, 0, 32'h43, 0);
    chk("ram_rd_43", load_data, 32'hDEAD_BEEF);
    drive(1, 0, 32'h2000_0000, 0);
    chk("unmapped", load_data, 32'h0);
    drive(1, 1, 32'h40, 32'h1111_2222);
    chk("ram_same_cycle_old", load_data, 32'hDEAD_BEEF);
    tick();
    cyc("ram_rd_new", 1, 0, 32'h40, 0);

    // 2: overflow then in-order drain
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) cyc("push", 0, 1, MMIO, 32'h41 + i);
    drive(1, 0, MMIO + 32'h04, 0);
    chk("txstat_ovf", load_data, 32'h0000_0805);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", tx_data, 8'h41 + i);
      tick();
    end
    chk("drained.tx_valid", tx_valid, 1'b0);
    cyc("ovf_clr", 0, 1, MMIO + 32'h04, 32'hFFFF_FFFF);
    drive(1, 0, MMIO + 32'h04, 0);
    chk("txstat_clr", load_data, 32'h0000_0002);

    // 3: push into full FIFO with a simultaneous pop
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc("fill", 0, 1, MMIO, 32'h61 + i);
    tx_ready = 1'b1;
    cyc("push_z", 0, 1, MMIO, 32'h5A);
    drive(1, 0, MMIO + 32'h04, 0);
    chk("txstat_full_no_ovf", load_data, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      chk("drain_z", tx_data, (i < 7) ? 8'(8'h62 + i) : 8'h5A);
      tick();
    end
    chk("drain_z.tx_valid", tx_valid, 1'b0);

    // Randomized traffic against the model (no tohost writes)
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        2: begin
          case ($urandom_range(0, 5))
            0: a = MMIO;
            1: a = MMIO + 32'h04;
            2: a = MMIO + 32'h08;
            3: a = MMIO + 32'h0C;
            4: a = MMIO + 32'h14;
            default: a = MMIO + 32'h20;
          endcase
        end
        3: a = MMIO + 32'($urandom_range(0, 3));
        4: a = 32'h1000_0000 + 32'($urandom_range(0, 65535));
        default: a = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
      endcase
      tx_ready = ($urandom_range(0, 1) == 1);
      cyc("rand", ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 4), a, $urandom());
    end

    // 4: timer after 100 cycles, shadow of the high word
    reset = 1'b1;
    drive(0, 0, MMIO + 32'h20, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    drive(1, 0, MMIO + 32'h08, 0);
    chk("time_lo_100", load_data, 32'd100);
    chk_load("time_lo_model");
    tick();
    drive(0, 0, MMIO + 32'h0C, 0);
    chk("time_hi_shadow", load_data, 32'd0);

    // 6: reset mid-operation flushes FIFO, keeps RAM
    tx_ready = 1'b0;
    cyc("ram_keep_wr", 0, 1, 32'h40, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) cyc("q3", 0, 1, MMIO, 32'h30 + i);
    chk("q3.tx_valid", tx_valid, 1'b1);
    reset = 1'b1;
    drive(0, 0, MMIO + 32'h20, 0);
    tick();
    reset = 1'b0;
    check_state("mid_reset");
    chk("mid_reset.tx_valid", tx_valid, 1'b0);
    drive(1, 0, 32'h40, 0);
    chk("ram_kept", load_data, 32'hCAFE_F00D);
    drive(1, 0, MMIO + 32'h08, 0);
    chk("timer_reset", load_data, 32'd0);

    // 5: halt via tohost
    cyc("tohost0", 0, 1, MMIO + 32'h10, 32'h0);
    chk("tohost0.halt", halt, 1'b0);
    cyc("tohost1", 0, 1, MMIO + 32'h10, 32'h1);
    chk("tohost1.halt", halt, 1'b1);
    chk("tohost1.code", halt_code, 32'h1);
    cyc("halted_ram_wr", 0, 1, 32'h40, 32'h1234);
    cyc("tohost5", 0, 1, MMIO + 32'h10, 32'h5);
    chk("tohost5.code", halt_code, 32'h1);
    cyc("halted_push", 0, 1, MMIO, 32'h77);
    chk("halted_push.tx_valid", tx_valid, 1'b0);
    drive(1, 0, 32'h40, 0);
    chk("halted_ram_rd", load_data, 32'hCAFE_F00D);
    drive(1, 0, MMIO + 32'h10, 0);
    chk("tohost_rd", load_data, 32'h1);

    // 4b: timer forced near the 32-bit carry; LO then HI must be consistent
    drive(1, 0, MMIO + 32'h08, 0);
    force dut.timer_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    chk("forced_lo", load_data, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    release dut.timer_q;
    timer_ok = 1'b0;
    drive(0, 0, MMIO + 32'h0C, 0);
    chk("forced_hi_shadow", load_data, 32'h0);

    // Reset clears halt
    reset = 1'b1;
    drive(0, 0, MMIO + 32'h20, 0);
    tick();
    reset = 1'b0;
    chk("final_reset.halt", halt, 1'b0);
    chk("final_reset.code", halt_code, 32'h0);
    drive(1, 0, MMIO + 32'h08, 0);
    chk("final_reset.timer", load_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
